// File: rtl/addr_recover_dsr_pkg.sv
// Shared constants and helpers for the DSR address calculator and its inverse.
package addr_dsr_pkg;
  localparam logic [7:0] DSR_BASE = 8'h80;
  localparam int         OFFSET_W = 8;
  localparam int         SUM_W    = 9;

  // Offset the forward calculator subtracts: (base - ptr) mod 256.
  function automatic logic [OFFSET_W-1:0] calc_offset(input logic [7:0] base,
                                                      input logic [7:0] ptr);
    return base - ptr;
  endfunction
endpackage

// File: rtl/addr_recover_dsr_pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or draining.
module addr_pipe_stage
  import addr_dsr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on a transfer, empty when the held entry leaves with nothing behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
endmodule

// File: rtl/addr_recover_dsr.sv
// Inverse DSR address calculator: count -> address, with range flag and error tally.
module addr_recover_dsr
  import addr_dsr_pkg::*;
#(
  parameter logic [7:0] BASE = addr_dsr_pkg::DSR_BASE,
  parameter int         ERRW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     count,
  input  logic [7:0]      ptr1,
  input  logic [7:0]      ptr2,
  input  logic [7:0]      b,
  input  logic            control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      address,
  output logic            range_err,
  output logic [ERRW-1:0] err_count,
  input  logic            err_clr
);
  localparam int S1_W = 1 + SUM_W + 8;   // {hi_err, sum9, b}
  localparam int S2_W = 1 + 8;           // {range_err, address}

  logic [7:0]       w_ptr_sel;
  logic [7:0]       w_offset;
  logic [SUM_W-1:0] w_sum9;
  logic             w_hi_err;
  logic [S1_W-1:0]  w_s1_in, w_s1_q;
  logic             w_s1_valid, w_s2_ready;
  logic [SUM_W-1:0] w_addr9;
  logic [S2_W-1:0]  w_s2_in, w_s2_q;
  logic [ERRW-1:0]  r_err_cnt;

  // Stage 1 arithmetic: undo the offset; any bit above 8 is unreachable.
  assign w_ptr_sel = control ? ptr1 : ptr2;
  assign w_offset  = calc_offset(BASE, w_ptr_sel);
  assign w_sum9    = count[8:0] + {1'b0, w_offset};
  assign w_hi_err  = |count[15:9];
  assign w_s1_in   = {w_hi_err, w_sum9, b};

  addr_pipe_stage #(.W(S1_W)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(in_valid), .o_ready(in_ready), .i_data(w_s1_in),
    .o_valid(w_s1_valid), .i_ready(w_s2_ready), .o_data(w_s1_q)
  );

  // Stage 2 arithmetic: remove b; a borrow into bit 8 means no 8-bit address fits.
  assign w_addr9 = w_s1_q[SUM_W+7:8] - {1'b0, w_s1_q[7:0]};
  assign w_s2_in = {w_s1_q[S1_W-1] | w_addr9[8], w_addr9[7:0]};

  addr_pipe_stage #(.W(S2_W)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(w_s1_valid), .o_ready(w_s2_ready), .i_data(w_s2_in),
    .o_valid(out_valid), .i_ready(out_ready), .o_data(w_s2_q)
  );

  assign range_err = w_s2_q[S2_W-1];
  assign address   = w_s2_q[7:0];
  assign err_count = r_err_cnt;

  // Saturating tally of consumed error results; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (err_clr)
      r_err_cnt <= '0;
    else if (out_valid && out_ready && range_err && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 1'b1;
  end
endmodule

// File: tb/tb_addr_recover_dsr.sv
// Randomized bench for addr_recover_dsr with an arithmetic reference model.
module tb_addr_recover_dsr;
  localparam int ERRW    = 4;              // small so saturation is reachable
  localparam int ERR_MAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, control, out_valid, out_ready;
  logic            range_err, err_clr;
  logic [15:0]     count;
  logic [7:0]      ptr1, ptr2, b, address;
  logic [ERRW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];       // expected {range_err, address} in acceptance order
  int  merr = 0;          // model error tally
  bit  prev_stall = 0;
  logic [8:0] prev_out;

  always #5 clk = ~clk;

  addr_recover_dsr #(.ERRW(ERRW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .count(count), .ptr1(ptr1), .ptr2(ptr2), .b(b), .control(control),
    .out_valid(out_valid), .out_ready(out_ready), .address(address),
    .range_err(range_err), .err_count(err_count), .err_clr(err_clr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int offset_of(input int p1, input int p2, input int ctl);
    int p = ctl ? p1 : p2;
    return ((128 - p) % 256 + 256) % 256;
  endfunction

  // address = count + offset - b; legal only if count < 512 and result < 256.
  function automatic logic [8:0] model(input int cnt, input int p1, input int p2,
                                       input int bb, input int ctl);
    int v = (cnt % 512) + offset_of(p1, p2, ctl) - bb;
    v = ((v % 512) + 512) % 512;
    model = {(cnt >= 512) || (v >= 256), 8'(v % 256)};
  endfunction

  // Compare process: outputs against the queue-based model every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      merr = 0;
      prev_stall = 0;
    end else begin
      logic [8:0] exp;
      bit ohs;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_err", range_err, prev_out[8]);
        if (!prev_out[8]) chk("stall_addr", address, prev_out[7:0]);
      end
      chk("err_count", err_count, merr);
      if (out_valid && q.size() == 0) chk("spurious_out", out_valid, 0);
      ohs = out_valid && out_ready;
      if (ohs && q.size() > 0) begin
        exp = q.pop_front();
        chk("range_err", range_err, exp[8]);
        if (!exp[8]) chk("address", address, exp[7:0]);
        if (err_clr) merr = 0;
        else if (exp[8] && merr < ERR_MAX) merr++;
      end else if (err_clr) merr = 0;
      if (in_valid && in_ready) q.push_back(model(count, ptr1, ptr2, b, control));
      prev_stall = out_valid && !out_ready;
      prev_out   = {range_err, address};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input int cnt, input int p1, input int p2, input int bb, input int ctl);
    count = 16'(cnt); ptr1 = 8'(p1); ptr2 = 8'(p2); b = 8'(bb); control = ctl[0];
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1; err_clr = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin tick(); n++; end
    if (n >= 200) chk("drain_timeout", q.size(), 0);
    tick();
  endtask

  // Single input on an empty pipe with literal expectations and latency check.
  task automatic direct(input string nm, input int cnt, input int p1, input int p2,
                        input int bb, input int ctl, input int ea, input int ee,
                        input bit clr);
    set_in(cnt, p1, p2, bb, ctl);
    in_valid = 1; out_ready = 1;
    tick();                                   // accepted into stage 1
    in_valid = 0;
    @(negedge clk) chk({nm, "_early"}, out_valid, 0);
    tick();                                   // moved to output stage
    err_clr = clr;
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_err"}, range_err, ee);
    if (!ee) chk({nm, "_addr"}, address, ea);
    tick();                                   // consumed
    err_clr = 0;
  endtask

  // Random stream; mode 0 feeds forward-computed counts, mode 1 arbitrary counts.
  task automatic run_random(input int n, input int mode);
    int sent = 0, cyc = 0;
    bit acc = 0;
    while (sent < n && cyc < n * 6 + 100) begin
      tick();
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        if (in_valid) begin
          int a = $urandom % 256, bb = $urandom % 256, p1 = $urandom % 256;
          int p2 = $urandom % 256, ctl = $urandom % 2, cnt;
          if (mode == 0)
            cnt = (((a + bb - offset_of(p1, p2, ctl)) % 512) + 512) % 512;
          else
            cnt = ($urandom % 4 == 0) ? $urandom % 65536 : $urandom % 512;
          set_in(cnt, p1, p2, bb, ctl);
        end
      end
      out_ready = ($urandom % 5) != 0;
      err_clr   = (mode == 1) && ($urandom % 64 == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      cyc++;
    end
    chk("random_sent", sent, n);
    drain();
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; err_clr = 0;
    set_in(0, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_address", address, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_err_count", err_count, 0);
    tick();

    direct("t1", 16'h01B5, 8'h10, 8'h00, 8'h05, 1, 8'h20, 0, 0);
    direct("t2a", 16'h00FF, 8'h00, 8'h80, 8'h00, 0, 8'hFF, 0, 0);
    direct("t2b", 16'h01FF, 8'h00, 8'h80, 8'h00, 0, 0, 1, 0);
    @(negedge clk) chk("t2_err_count", err_count, 1);
    tick();
    direct("t3", 16'h0200, 8'h33, 8'h44, 8'h12, 1, 0, 1, 1);
    @(negedge clk) chk("t3_err_clr", err_count, 0);
    tick();

    // 8-entry stream, output stalled for three cycles after two entries.
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
        out_ready = !(cyc >= 2 && cyc <= 4);
        in_valid  = idx < 8;
        set_in((idx * 97 + 40) % 1024, idx * 13, idx * 29, idx * 7, idx % 2);
        @(negedge clk);
        if (cyc >= 2 && cyc <= 4) chk("stall_in_ready", in_ready, 0);
        if (in_valid && in_ready) idx++;
        tick();
      end
      chk("stream_accepted", idx, 8);
      drain();
    end

    run_random(10000, 0);
    run_random(3000, 1);

    // Reset with both stages holding data.
    out_ready = 0;
    set_in(16'h0011, 1, 2, 3, 0); in_valid = 1;
    tick();
    set_in(16'h0022, 4, 5, 6, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_full_valid", out_valid, 1);
    chk("pre_rst_full_ready", in_ready, 0);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    tick();
    direct("post_rst", 16'h01B5, 8'h10, 8'h00, 8'h05, 1, 8'h20, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
